// File: rtl/sys_rst_pkg.sv
// rtl/sys_rst_pkg.sv - shared states, defaults and sizing helpers for the reset sequencer
package sys_rst_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_STABLE    = 3'd1,
    ST_SEQ       = 3'd2,
    ST_RUN       = 3'd3,
    ST_SOFT_HOLD = 3'd4
  } state_e;

  localparam int DEF_SYNC_STAGES      = 2;
  localparam int DEF_STABLE_CYCLES    = 1024;
  localparam int DEF_STAGE_GAP        = 16;
  localparam int DEF_SOFT_HOLD_CYCLES = 64;

  localparam int                    LOSS_CNT_W   = 8;
  localparam logic [LOSS_CNT_W-1:0] LOSS_CNT_MAX = '1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  // Counters only ever reach N-1, so clog2(N) bits are enough.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/sys_rst_sequencer_if.sv
// rtl/sys_rst_sequencer_if.sv - lock/request inputs and reset outputs of the sequencer
interface sys_rst_sequencer_if;
  import sys_rst_pkg::*;

  logic                  mmcm_locked;
  logic                  soft_rst_req;
  logic                  clr_count;
  logic                  rst_periph;
  logic                  rst_core;
  logic                  rst_user;
  logic                  ready;
  logic [LOSS_CNT_W-1:0] lock_loss_count;

  modport master (
    output mmcm_locked, soft_rst_req, clr_count,
    input  rst_periph, rst_core, rst_user, ready, lock_loss_count
  );

  modport slave (
    input  mmcm_locked, soft_rst_req, clr_count,
    output rst_periph, rst_core, rst_user, ready, lock_loss_count
  );

endinterface

// File: rtl/cdc_sync_bit.sv
// rtl/cdc_sync_bit.sv - multi-flop single-bit synchronizer with async active-low reset
module cdc_sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      sync_q <= '0;
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/sys_rst_sequencer.sv
// rtl/sys_rst_sequencer.sv - staged peripheral/core/user reset release gated on a stable MMCM lock
module sys_rst_sequencer
  import sys_rst_pkg::*;
#(
  parameter int SYNC_STAGES      = DEF_SYNC_STAGES,
  parameter int STABLE_CYCLES    = DEF_STABLE_CYCLES,
  parameter int STAGE_GAP        = DEF_STAGE_GAP,
  parameter int SOFT_HOLD_CYCLES = DEF_SOFT_HOLD_CYCLES
) (
  input  logic               sys_clk,
  input  logic               sys_clk_rst_n,
  sys_rst_sequencer_if.slave bus
);

  localparam int CNT_SPAN = max3(STABLE_CYCLES, STAGE_GAP, SOFT_HOLD_CYCLES);
  localparam int CW       = cnt_width(CNT_SPAN);

  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST    = CW'(STAGE_GAP - 1);
  localparam logic [CW-1:0] SOFT_LAST   = CW'(SOFT_HOLD_CYCLES - 1);

  state_e                state_q;
  logic [CW-1:0]         cnt_q;
  logic [CW-1:0]         cnt_inc;
  logic                  rst_periph_q;
  logic                  rst_core_q;
  logic                  rst_user_q;
  logic                  ready_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_q;
  logic [LOSS_CNT_W-1:0] loss_cnt_d;
  logic                  lock_s;
  logic                  lock_lost;
  logic                  loss_counted;

  cdc_sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk_i   (sys_clk),
    .rst_n_i (sys_clk_rst_n),
    .d_i     (bus.mmcm_locked),
    .q_o     (lock_s)
  );

  assign cnt_inc      = cnt_q + CW'(1);
  assign lock_lost    = !lock_s && (state_q != ST_IDLE);
  // Only losses after release has begun are interesting to software.
  assign loss_counted = !lock_s && (state_q == ST_SEQ || state_q == ST_RUN);

  always_comb begin
    loss_cnt_d = loss_cnt_q;
    if (bus.clr_count) begin
      loss_cnt_d = '0;
    end else if (loss_counted && (loss_cnt_q != LOSS_CNT_MAX)) begin
      loss_cnt_d = loss_cnt_q + LOSS_CNT_W'(1);
    end
  end

  always_ff @(posedge sys_clk or negedge sys_clk_rst_n) begin
    if (!sys_clk_rst_n) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      rst_periph_q <= 1'b1;
      rst_core_q   <= 1'b1;
      rst_user_q   <= 1'b1;
      ready_q      <= 1'b0;
      loss_cnt_q   <= '0;
    end else begin
      loss_cnt_q <= loss_cnt_d;
      if (lock_lost) begin
        // Lock loss overrides everything, including a same-cycle soft request.
        state_q      <= ST_IDLE;
        cnt_q        <= '0;
        rst_periph_q <= 1'b1;
        rst_core_q   <= 1'b1;
        rst_user_q   <= 1'b1;
        ready_q      <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            cnt_q        <= '0;
            rst_periph_q <= 1'b1;
            rst_core_q   <= 1'b1;
            rst_user_q   <= 1'b1;
            ready_q      <= 1'b0;
            if (lock_s) begin
              state_q <= ST_STABLE;
            end
          end
          ST_STABLE: begin
            if (cnt_q == STABLE_LAST) begin
              state_q      <= ST_SEQ;
              cnt_q        <= '0;
              rst_periph_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          ST_SEQ: begin
            if (cnt_q == GAP_LAST) begin
              cnt_q <= '0;
              if (rst_core_q) begin
                rst_core_q <= 1'b0;
              end else begin
                rst_user_q <= 1'b0;
                ready_q    <= 1'b1;
                state_q    <= ST_RUN;
              end
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          ST_RUN: begin
            cnt_q <= '0;
            if (bus.soft_rst_req) begin
              state_q      <= ST_SOFT_HOLD;
              rst_periph_q <= 1'b1;
              rst_core_q   <= 1'b1;
              rst_user_q   <= 1'b1;
              ready_q      <= 1'b0;
            end
          end
          ST_SOFT_HOLD: begin
            // Lock is already known good here, so the stability window is skipped.
            if (cnt_q == SOFT_LAST) begin
              state_q      <= ST_SEQ;
              cnt_q        <= '0;
              rst_periph_q <= 1'b0;
            end else begin
              cnt_q <= cnt_inc;
            end
          end
          default: begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            rst_periph_q <= 1'b1;
            rst_core_q   <= 1'b1;
            rst_user_q   <= 1'b1;
            ready_q      <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.rst_periph      = rst_periph_q;
  assign bus.rst_core        = rst_core_q;
  assign bus.rst_user        = rst_user_q;
  assign bus.ready           = ready_q;
  assign bus.lock_loss_count = loss_cnt_q;

endmodule

// File: tb/tb_sys_rst_sequencer.sv
// tb/tb_sys_rst_sequencer.sv - scoreboarded timeline checks for sys_rst_sequencer
module tb_sys_rst_sequencer;

  typedef struct {
    int         rel;
    logic [3:0] outs;
    string      nm;
  } nom_t;

  typedef struct {
    int         at;
    logic [3:0] outs;
    logic [7:0] cnt;
    string      nm;
  } exp_t;

  logic sys_clk       = 1'b0;
  logic sys_clk_rst_n = 1'b1;
  int   cyc           = 0;
  int   n_checks      = 0;
  int   n_pass        = 0;
  int   exp_cnt       = 0;
  nom_t nominal[6];
  exp_t sb[$];
  exp_t cur;
  int   base;

  sys_rst_sequencer_if bus();

  sys_rst_sequencer #(
    .SYNC_STAGES      (2),
    .STABLE_CYCLES    (16),
    .STAGE_GAP        (4),
    .SOFT_HOLD_CYCLES (8)
  ) dut (
    .sys_clk       (sys_clk),
    .sys_clk_rst_n (sys_clk_rst_n),
    .bus           (bus)
  );

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc++;

  // outs = {rst_periph, rst_core, rst_user, ready}
  always @(negedge sys_clk) begin
    while (sb.size() != 0 && sb[0].at <= cyc) begin
      cur = sb.pop_front();
      n_checks++;
      if (cur.at == cyc &&
          {bus.rst_periph, bus.rst_core, bus.rst_user, bus.ready} === cur.outs &&
          bus.lock_loss_count === cur.cnt) begin
        n_pass++;
      end else begin
        $display("FAIL %s @edge %0d (due %0d): outs=%b cnt=%0d, required outs=%b cnt=%0d",
                 cur.nm, cyc, cur.at,
                 {bus.rst_periph, bus.rst_core, bus.rst_user, bus.ready},
                 bus.lock_loss_count, cur.outs, cur.cnt);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input int at, input logic [3:0] outs, input int c, input string nm);
    sb.push_back('{at, outs, 8'(c), nm});
  endtask

  task automatic seq_expect(input int b, input int c, input int upto);
    foreach (nominal[i]) begin
      if (nominal[i].rel <= upto) push(b + nominal[i].rel, nominal[i].outs, c, nominal[i].nm);
    end
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 200) begin
      tick(1);
      guard++;
    end
    if (sb.size() != 0) begin
      n_checks++;
      $display("FAIL drain timeout: %0d expectations pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, required %0h", nm, act, req);
  endtask

  task automatic wait_ready(input logic val, input int bound, input string nm);
    int k = 0;
    while (bus.ready !== val && k < bound) begin
      tick(1);
      k++;
    end
    if (bus.ready !== val) begin
      n_checks++;
      $display("FAIL %s timeout: ready=%b, required %b", nm, bus.ready, val);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    nominal[0] = '{18, 4'b1110, "pre_periph"};
    nominal[1] = '{19, 4'b0110, "periph_rel"};
    nominal[2] = '{22, 4'b0110, "pre_core"};
    nominal[3] = '{23, 4'b0010, "core_rel"};
    nominal[4] = '{26, 4'b0010, "pre_user"};
    nominal[5] = '{27, 4'b0001, "user_ready"};

    bus.mmcm_locked  = 1'b0;
    bus.soft_rst_req = 1'b0;
    bus.clr_count    = 1'b0;

    // Async reset before any clock edge
    #2 sys_clk_rst_n = 1'b0;
    #1;
    check("reset_outs", 32'({bus.rst_periph, bus.rst_core, bus.rst_user, bus.ready}), 32'b1110);
    check("reset_count", 32'(bus.lock_loss_count), 32'd0);
    tick(2);
    sys_clk_rst_n = 1'b1;
    tick(2);

    // Nominal sequence from lock
    base = cyc;
    bus.mmcm_locked = 1'b1;
    seq_expect(base, exp_cnt, 27);
    drain();

    // Soft reset in RUN, plus a request in SEQ that must be ignored
    base = cyc;
    push(base + 1,  4'b1110, exp_cnt, "soft_assert");
    push(base + 8,  4'b1110, exp_cnt, "soft_hold");
    push(base + 9,  4'b0110, exp_cnt, "soft_periph");
    push(base + 12, 4'b0110, exp_cnt, "soft_ignored_seq");
    push(base + 13, 4'b0010, exp_cnt, "soft_core");
    push(base + 16, 4'b0010, exp_cnt, "soft_pre_user");
    push(base + 17, 4'b0001, exp_cnt, "soft_ready");
    bus.soft_rst_req = 1'b1;
    tick(1);
    bus.soft_rst_req = 1'b0;
    tick(9);
    bus.soft_rst_req = 1'b1;
    tick(1);
    bus.soft_rst_req = 1'b0;
    drain();

    // Loss in RUN
    base = cyc;
    bus.mmcm_locked = 1'b0;
    push(base + 2, 4'b0001, exp_cnt, "run_pre_loss");
    exp_cnt++;
    push(base + 3, 4'b1110, exp_cnt, "run_loss");
    drain();
    tick(2);

    // Relock, drop at edge 25
    base = cyc;
    bus.mmcm_locked = 1'b1;
    seq_expect(base, exp_cnt, 27);
    exp_cnt++;
    push(base + 28, 4'b1110, exp_cnt, "loss_at_28");
    tick(25);
    bus.mmcm_locked = 1'b0;
    drain();
    tick(2);

    // Relock, drop while still in SEQ
    base = cyc;
    bus.mmcm_locked = 1'b1;
    seq_expect(base, exp_cnt, 19);
    push(base + 22, 4'b0110, exp_cnt, "seq_pre_loss");
    exp_cnt++;
    push(base + 23, 4'b1110, exp_cnt, "seq_loss");
    tick(20);
    bus.mmcm_locked = 1'b0;
    drain();
    tick(2);

    // Relock resequences with identical spacing
    base = cyc;
    bus.mmcm_locked = 1'b1;
    seq_expect(base, exp_cnt, 27);
    drain();
    base = cyc;
    bus.mmcm_locked = 1'b0;
    exp_cnt++;
    push(base + 3, 4'b1110, exp_cnt, "run_loss2");
    drain();
    tick(2);

    // 10-cycle glitch in STABLE restarts the window, no count
    base = cyc;
    bus.mmcm_locked = 1'b1;
    push(base + 8,  4'b1110, exp_cnt, "glitch_stable");
    push(base + 19, 4'b1110, exp_cnt, "glitch_no_release");
    push(base + 34, 4'b1110, exp_cnt, "glitch_pre_periph");
    push(base + 35, 4'b0110, exp_cnt, "glitch_periph");
    push(base + 43, 4'b0001, exp_cnt, "glitch_ready");
    tick(6);
    bus.mmcm_locked = 1'b0;
    tick(10);
    bus.mmcm_locked = 1'b1;
    drain();

    // Async reset mid-SEQ between edges
    base = cyc;
    bus.mmcm_locked = 1'b0;
    exp_cnt++;
    push(base + 3, 4'b1110, exp_cnt, "run_loss3");
    drain();
    tick(2);
    base = cyc;
    bus.mmcm_locked = 1'b1;
    push(base + 19, 4'b0110, exp_cnt, "pre_rst_periph");
    push(base + 20, 4'b0110, exp_cnt, "pre_rst_seq");
    tick(21);
    #2 sys_clk_rst_n = 1'b0;
    #1;
    check("midseq_rst_outs", 32'({bus.rst_periph, bus.rst_core, bus.rst_user, bus.ready}), 32'b1110);
    check("midseq_rst_count", 32'(bus.lock_loss_count), 32'd0);
    #3 sys_clk_rst_n = 1'b1;
    exp_cnt = 0;
    push(base + 39, 4'b1110, exp_cnt, "rst_restart_hold");
    push(base + 40, 4'b0110, exp_cnt, "rst_restart_periph");
    push(base + 48, 4'b0001, exp_cnt, "rst_restart_ready");
    drain();

    // Loss during SOFT_HOLD: back to IDLE, not counted
    base = cyc;
    push(base + 1,  4'b1110, exp_cnt, "sh_assert");
    push(base + 9,  4'b1110, exp_cnt, "sh_loss_no_seq");
    push(base + 12, 4'b1110, exp_cnt, "sh_loss_idle");
    bus.soft_rst_req = 1'b1;
    tick(1);
    bus.soft_rst_req = 1'b0;
    bus.mmcm_locked  = 1'b0;
    drain();

    // Saturation over 300 lock cycles
    for (int i = 0; i < 300; i++) begin
      bus.mmcm_locked = 1'b1;
      wait_ready(1'b1, 60, "toggle_up");
      bus.mmcm_locked = 1'b0;
      wait_ready(1'b0, 10, "toggle_down");
      if (exp_cnt != 255) exp_cnt++;
    end
    tick(1);
    check("sat_count", 32'(bus.lock_loss_count), 32'(exp_cnt));

    // Clear wins over a simultaneous loss increment
    bus.mmcm_locked = 1'b1;
    wait_ready(1'b1, 60, "clr_up");
    base = cyc;
    bus.mmcm_locked = 1'b0;
    push(base + 2, 4'b0001, exp_cnt, "clr_pre");
    exp_cnt = 0;
    push(base + 3, 4'b1110, exp_cnt, "clr_wins");
    tick(2);
    bus.clr_count = 1'b1;
    tick(1);
    bus.clr_count = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
